// File: rtl/starfield_seq.sv
// starfield_seq: per-frame sequencer for a starfield pixel LFSR.
// At each frame start it loads the pixel LFSR with the current seed and
// enables it on every painted pixel. After the full paint area has been
// covered it steps the seed 'speed' times, which scrolls the field.
// Optional feature macro: STARFIELD_SEQ_FRAMECNT_EN adds a 16-bit frame_cnt
// output that counts LOAD cycles and wraps from 16'hFFFF to 0.
module starfield_seq #(
  parameter int                LFSRW    = 17,
  parameter logic [LFSRW-1:0]  TAPS     = 17'h02000,
  parameter int                SPEEDW   = 8,
  parameter logic [LFSRW-1:0]  SEED_DEF = 17'h00001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              paint,
  input  logic              run,
  input  logic [SPEEDW-1:0] speed,
  output logic              lfsr_en,
  output logic              lfsr_load,
  output logic [LFSRW-1:0]  lfsr_seed,
  output logic              busy,
  output logic              overrun
`ifdef STARFIELD_SEQ_FRAMECNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAINT,
    S_ADVANCE,
    S_WAIT
  } state_t;

  // Last pixel index of the paint area (2^LFSRW - 1).
  localparam logic [LFSRW-1:0] PIX_LAST = '1;

  state_t              state_reg, state_next;
  logic [LFSRW-1:0]    seed_reg, seed_next;
  logic [LFSRW-1:0]    pix_cnt_reg, pix_cnt_next;
  logic [SPEEDW-1:0]   step_cnt_reg, step_cnt_next;
  logic                lfsr_en_reg, lfsr_en_next;
  logic                lfsr_load_reg, lfsr_load_next;
  logic [LFSRW-1:0]    lfsr_seed_reg, lfsr_seed_next;
  logic                busy_reg, busy_next;
  logic                overrun_reg, overrun_next;

  // Seed step: rotate left by one, XOR the feedback mask when the MSB
  // was set, and fall back to SEED_DEF if the result would lock up at 0.
  logic [LFSRW-1:0]    seed_rot;
  logic [LFSRW-1:0]    seed_fb;
  logic [LFSRW-1:0]    seed_stepped;

  genvar gi;
  generate
    for (gi = 0; gi < LFSRW; gi++) begin : g_rot
      if (gi == 0) begin : g_wrap
        assign seed_rot[gi] = seed_reg[LFSRW-1];
      end else begin : g_shift
        assign seed_rot[gi] = seed_reg[gi-1];
      end
    end
  endgenerate

  assign seed_fb      = seed_rot ^ (seed_reg[LFSRW-1] ? TAPS : '0);
  assign seed_stepped = (seed_fb == '0) ? SEED_DEF : seed_fb;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_next     = state_reg;
    seed_next      = seed_reg;
    pix_cnt_next   = pix_cnt_reg;
    step_cnt_next  = step_cnt_reg;
    overrun_next   = overrun_reg;
    lfsr_seed_next = lfsr_seed_reg;

    case (state_reg)
      S_IDLE, S_WAIT: begin
        if (frame_start) begin
          state_next = run ? S_LOAD : S_IDLE;
        end
      end

      S_LOAD: begin
        pix_cnt_next = '0;
        if (frame_start) begin
          overrun_next = 1'b1;
          state_next   = run ? S_LOAD : S_IDLE;
        end else begin
          state_next = S_PAINT;
        end
      end

      S_PAINT: begin
        if (frame_start) begin
          overrun_next = 1'b1;
          state_next   = run ? S_LOAD : S_IDLE;
        end else if (paint) begin
          pix_cnt_next = pix_cnt_reg + 1'b1;
          if (pix_cnt_reg == PIX_LAST) begin
            if (speed == '0) begin
              state_next = run ? S_WAIT : S_IDLE;
            end else begin
              // Speed is captured here so later changes cannot stretch
              // or shorten the advance phase of this frame.
              step_cnt_next = speed;
              state_next    = S_ADVANCE;
            end
          end
        end
      end

      S_ADVANCE: begin
        if (frame_start) begin
          // Remaining steps are dropped; the seed keeps its current value.
          overrun_next = 1'b1;
          state_next   = run ? S_LOAD : S_IDLE;
        end else begin
          seed_next     = seed_stepped;
          step_cnt_next = step_cnt_reg - 1'b1;
          if (step_cnt_reg == {{(SPEEDW-1){1'b0}}, 1'b1}) begin
            state_next = run ? S_WAIT : S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // The seed presented to the pixel LFSR is latched on entry to LOAD.
    if (state_next == S_LOAD) begin
      lfsr_seed_next = seed_reg;
    end

    lfsr_load_next = (state_next == S_LOAD);
    // Pixel enable is paint delayed by one cycle, suppressed when a load
    // strobe is issued in the same cycle so the two never collide.
    lfsr_en_next   = (state_reg == S_PAINT) && paint && (state_next != S_LOAD);
    busy_next      = (state_next == S_LOAD) || (state_next == S_PAINT) ||
                     (state_next == S_ADVANCE);
  end

  // State and output registers; reset acts immediately, not at a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      seed_reg      <= SEED_DEF;
      pix_cnt_reg   <= '0;
      step_cnt_reg  <= '0;
      lfsr_en_reg   <= 1'b0;
      lfsr_load_reg <= 1'b0;
      lfsr_seed_reg <= SEED_DEF;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      seed_reg      <= seed_next;
      pix_cnt_reg   <= pix_cnt_next;
      step_cnt_reg  <= step_cnt_next;
      lfsr_en_reg   <= lfsr_en_next;
      lfsr_load_reg <= lfsr_load_next;
      lfsr_seed_reg <= lfsr_seed_next;
      busy_reg      <= busy_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign lfsr_en   = lfsr_en_reg;
  assign lfsr_load = lfsr_load_reg;
  assign lfsr_seed = lfsr_seed_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

`ifdef STARFIELD_SEQ_FRAMECNT_EN
  logic [15:0] frame_cnt_reg;

  // Frame counter: bumps alongside every LOAD cycle, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (state_next == S_LOAD) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

endmodule
